// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - two-port memory arbiter, one outstanding transaction
// Optional feature: define MEMORY_ARBITER_ROUND_ROBIN_EN for round-robin instead of fixed priority.
module memory_arbiter (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_request,
    input  logic [1:0]       req_enable,
    input  logic [1:0]       req_command,
    input  logic [1:0][31:0] req_address,
    input  logic [1:0][31:0] req_write_data,
    input  logic [1:0][3:0]  req_write_mask,
    output logic [1:0]       req_ready,
    output logic [1:0]       req_valid,
    output logic [31:0]      req_read_data,
    output logic             mem_enable,
    output logic             mem_command,
    output logic [31:0]      mem_address,
    output logic [31:0]      mem_write_data,
    output logic [3:0]       mem_write_mask,
    input  logic             mem_ready,
    input  logic             mem_valid,
    input  logic [31:0]      mem_read_data,
    output logic             grant,
    output logic [1:0]       debug_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } state_t;

    localparam logic CMD_READ = 1'b0;

    state_t state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_grant_q, last_grant_d;
    logic   accept;
    logic   complete;
    logic   idle_winner;
    logic   done_winner;

    // With no request pending the winner is never used, so the last-grant
    // fallback only keeps the expression total.
    function automatic logic pick(input logic [1:0] req, input logic last);
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        if (req == 2'b11) begin
            return ~last;
        end
        return req[0] ? 1'b0 : (req[1] ? 1'b1 : last);
`else
        return req[0] ? 1'b0 : (req[1] ? 1'b1 : last);
`endif
    endfunction

    // On completion the port just served becomes the new last grant, so
    // arbitration in that same cycle must already see it.
    assign idle_winner = pick(req_request, last_grant_q);
    assign done_winner = pick(req_request, grant_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_grant_d   = last_grant_q;
        accept         = 1'b0;
        complete       = 1'b0;
        req_ready      = 2'b00;
        req_valid      = 2'b00;
        req_read_data  = 32'd0;
        mem_enable     = 1'b0;
        mem_command    = CMD_READ;
        mem_address    = 32'd0;
        mem_write_data = 32'd0;
        mem_write_mask = 4'd0;

        case (state_q)
            IDLE: begin
                if (|req_request) begin
                    grant_d = idle_winner;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                req_ready[grant_q] = mem_ready;
                mem_command        = req_command[grant_q];
                mem_address        = req_address[grant_q];
                mem_write_data     = req_write_data[grant_q];
                mem_write_mask     = req_write_mask[grant_q];
                accept             = req_enable[grant_q] & mem_ready;
                mem_enable         = accept;
                if (accept) begin
                    if (mem_valid) begin
                        complete = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end else if (!req_request[grant_q]) begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (mem_valid) begin
                    complete = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            req_valid[grant_q] = 1'b1;
            req_read_data      = mem_read_data;
            last_grant_d       = grant_q;
            if (|req_request) begin
                grant_d = done_winner;
                state_d = GRANT;
            end else begin
                state_d = IDLE;
            end
        end
    end

    assign grant       = grant_q;
    assign debug_state = state_q;

endmodule
